// File: rtl/mux_pkg.sv
// Shared types for the N-to-1 packet mux: output-register state and pointer width helper.
// No logic of its own; imported by the arbiter and the mux top.
// Backpressure: not applicable.
package mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: round-robin from ptr upward (mode=0) or lowest index wins (mode=1).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic          mode,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    // Each requester gets a distance from the search start; the smallest distance wins.
    always_comb begin
        int best;
        int off;
        grant = '0;
        best  = N;
        off   = 0;
        for (int i = 0; i < N; i++) begin
            if (mode)
                off = i;
            else if (i >= int'(ptr))
                off = i - int'(ptr);
            else
                off = i + N - int'(ptr);
            if (req[i] && off < best) begin
                best     = off;
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 mux with round-robin/fixed arbitration into a single-entry output register; MUX_PKT_LOCK_EN holds grant for a whole packet.
// Latency: one cycle from an input transfer to out_valid.
// Backpressure: in_ready follows out_ready when full, so a drain and a new load can share a cycle.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [N*WIDTH-1:0]    in_data,
    input  logic [N-1:0]          in_valid,
    input  logic [N-1:0]          in_last,
    output logic [N-1:0]          in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [$clog2(N)-1:0]  out_sel,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PW = ptr_w(N);

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gidx;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             accept;
    logic             load;

`ifdef MUX_PKT_LOCK_EN
    logic          locked;
    logic [PW-1:0] lock_ch;

    // Mid-packet, only the owning channel is visible to the arbiter.
    assign req = locked ? (in_valid & (N'(1) << lock_ch)) : in_valid;
`else
    assign req = in_valid;
`endif

    rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .req   (req),
        .mode  (mode),
        .ptr   (ptr),
        .grant (grant)
    );

    assign accept    = (state == EMPTY) | out_ready;
    assign load      = accept & (|req) & ~rst;
    assign in_ready  = (accept & ~rst) ? grant : '0;
    assign out_valid = (state == FULL);

    always_comb begin
        gidx     = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gidx     = PW'(i);
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_last = in_last[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (out_ready && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
            out_last <= 1'b0;
            ptr      <= '0;
        end else if (load) begin
            out_data <= sel_data;
            out_sel  <= gidx;
            out_last <= sel_last;
            if (!mode)
                ptr <= (gidx == PW'(N-1)) ? '0 : gidx + PW'(1);
        end
    end

`ifdef MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (load) begin
            locked  <= ~sel_last;
            lock_ch <= gidx;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Bench for mux_nto1_rr: stimulus table with expected grants, scoreboard of expected output beats.
module tb_mux_nto1_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;

    mux_nto1_rr #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mode;
        logic [3:0] vld;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] exp_rdy;
    } vec_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] dat;
        logic       last;
    } beat_t;

    vec_t  tbl[$];
    beat_t sb[$];
    int    checks = 0;
    int    fails  = 0;

    function automatic vec_t mk(input logic m, input logic [3:0] v, input logic [3:0] l,
                                input logic r, input logic [3:0] e);
        vec_t t;
        t.mode    = m;
        t.vld     = v;
        t.last    = l;
        t.ordy    = r;
        t.exp_rdy = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive a row, check the combinational grant and the held beat, update the scoreboard.
    task automatic apply(input vec_t v);
        beat_t b;
        @(posedge clk);
        #1;
        mode      = v.mode;
        in_valid  = v.vld;
        in_last   = v.last;
        out_ready = v.ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(v.exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            if (out_valid) begin
                chk("out_sel", 32'(out_sel), 32'(sb[0].sel));
                chk("out_data", 32'(out_data), 32'(sb[0].dat));
                chk("out_last", 32'(out_last), 32'(sb[0].last));
            end
            if (out_ready) void'(sb.pop_front());
        end
        if ((v.exp_rdy & v.vld) != 4'b0000) begin
            b = '0;
            for (int i = 0; i < N; i++) begin
                if (v.exp_rdy[i]) begin
                    b.sel  = 2'(i);
                    b.dat  = 8'(160 + i);
                    b.last = v.last[i];
                end
            end
            sb.push_back(b);
        end
    endtask

    initial begin
        // Round-robin from reset, pointer wraps 3 -> 0
        tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001));
        // Backpressure: held beat, no grants; release loads in the same cycle
        tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010));
        // Fixed priority, then back to round-robin from the untouched pointer
        tbl.push_back(mk(1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0010));
        tbl.push_back(mk(1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0010));
        tbl.push_back(mk(1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0010));
        tbl.push_back(mk(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1000));
        // Pointer to 3, then sparse wrap and a lone requester
        tbl.push_back(mk(1'b0, 4'b0100, 4'b1111, 1'b1, 4'b0100));
        tbl.push_back(mk(1'b0, 4'b1001, 4'b1111, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1001, 4'b1111, 1'b1, 4'b0001));
        tbl.push_back(mk(1'b0, 4'b0100, 4'b1011, 1'b1, 4'b0100));
        tbl.push_back(mk(1'b0, 4'b0100, 4'b1011, 1'b1, 4'b0100));
        tbl.push_back(mk(1'b0, 4'b0100, 4'b1011, 1'b1, 4'b0100));
        // Idle: nothing granted, register drains
        tbl.push_back(mk(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000));
        tbl.push_back(mk(1'b0, 4'b0100, 4'b1111, 1'b1, 4'b0100));
`ifdef MUX_PKT_LOCK_EN
        // Channel 1 packet of three beats holds the grant against channel 0
        tbl.push_back(mk(1'b0, 4'b0001, 4'b1111, 1'b1, 4'b0001));
        tbl.push_back(mk(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0010));
        tbl.push_back(mk(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0010));
        tbl.push_back(mk(1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0010));
        tbl.push_back(mk(1'b0, 4'b0011, 4'b1111, 1'b1, 4'b0001));
`endif
        tbl.push_back(mk(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000));
        // Loads channel 2 and holds it for the mid-operation reset below
        tbl.push_back(mk(1'b0, 4'b0100, 4'b1111, 1'b0, 4'b0100));

        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        mode      = 1'b0;
        in_last   = 4'b0000;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        rst       = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(in_ready), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", 32'(out_data), 32'h0);
        chk("rst out_sel", 32'(out_sel), 32'h0);
        chk("rst out_last", 32'(out_last), 32'h0);
        rst      = 1'b0;
        in_valid = 4'b0000;

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k]);

        // Reset while a beat is held and downstream is ready
        @(posedge clk);
        #1;
        chk("held before rst", 32'(out_valid), 32'h1);
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("mid rst in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("mid rst out_valid", 32'(out_valid), 32'h0);
        chk("mid rst out_data", 32'(out_data), 32'h0);
        chk("mid rst out_sel", 32'(out_sel), 32'h0);
        rst      = 1'b0;
        in_valid = 4'b0000;
        sb.delete();

        // Pointer must restart at channel 0
        apply(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001));
        apply(mk(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000));
        apply(mk(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
